// File: rtl/rgb_classifier.sv
// ---------------------------------------------------------------------------
// rgb_classifier
//
// Purpose:
//   Takes one raw 48-bit colour sensor sample (three 16-bit channels) and
//   classifies it into a coarse colour. Each channel is normalised against
//   the channel sum with a bit-serial restoring divider. This gives an
//   8-bit fraction per channel, and a small rule table picks the colour.
//   The result is held with a valid/ack handshake until the consumer
//   (motor side) accepts it.
//
// Ports:
//   i_clk        in   1   single clock, rising edge
//   i_rst        in   1   synchronous active-high reset
//   i_start      in   1   one-cycle sample strobe (only honoured in IDLE)
//   i_rgb_value  in  48   {B hi, B lo, R hi, R lo, G hi, G lo}
//   i_ack        in   1   consumer acknowledge (only honoured in HOLD)
//   o_color      out  3   0 WHITE, 1 YELLOW, 2 ORANGE, 3 RED, 4 GREEN,
//                         5 BLUE, 7 UNKNOWN
//   o_valid      out  1   o_color valid, held until acknowledged
//   o_busy       out  1   high whenever the FSM is not in IDLE
//
// Optional feature:
//   RGB_CLASSIFIER_AVG_EN - when defined, four accepted samples are
//   averaged before classification. The default build classifies every
//   sample and contains no accumulator or counter logic.
// ---------------------------------------------------------------------------
module rgb_classifier #(
    parameter int unsigned DARK_MIN     = 64,
    parameter int unsigned WHITE_SPREAD = 24,
    parameter int unsigned YELLOW_TOL   = 20,
    parameter int unsigned YELLOW_B_MAX = 40,
    parameter int unsigned ORANGE_G_MIN = 60
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [47:0] i_rgb_value,
    input  logic        i_ack,
    output logic [2:0]  o_color,
    output logic        o_valid,
    output logic        o_busy
);

    localparam logic [17:0] DARK_MIN_W     = 18'(DARK_MIN);
    localparam logic [7:0]  WHITE_SPREAD_W = 8'(WHITE_SPREAD);
    localparam logic [7:0]  YELLOW_TOL_W   = 8'(YELLOW_TOL);
    localparam logic [7:0]  YELLOW_B_MAX_W = 8'(YELLOW_B_MAX);
    localparam logic [7:0]  ORANGE_G_MIN_W = 8'(ORANGE_G_MIN);

    localparam logic [2:0] COLOR_WHITE   = 3'd0;
    localparam logic [2:0] COLOR_YELLOW  = 3'd1;
    localparam logic [2:0] COLOR_ORANGE  = 3'd2;
    localparam logic [2:0] COLOR_RED     = 3'd3;
    localparam logic [2:0] COLOR_GREEN   = 3'd4;
    localparam logic [2:0] COLOR_BLUE    = 3'd5;
    localparam logic [2:0] COLOR_UNKNOWN = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SUM,
        ST_DIV,
        ST_CLASS,
        ST_HOLD
    } state_t;

    state_t state;
    state_t state_next;

    // The sensor sends G in the low word, R in the middle and B on top.
    logic [15:0] in_r;
    logic [15:0] in_g;
    logic [15:0] in_b;

    logic [15:0] r_val;
    logic [15:0] g_val;
    logic [15:0] b_val;
    logic [17:0] sum_val;
    logic        dark;

    logic [17:0] sum_comb;
    logic        sum_dark;

    logic [17:0] div_rem;
    logic [6:0]  div_quot;
    logic [2:0]  div_bit;
    logic [1:0]  div_chan;
    logic [18:0] div_trial;
    logic        div_qbit;
    logic [17:0] div_rem_next;
    logic [7:0]  div_frac;
    logic        div_last;

    logic [7:0]  rf;
    logic [7:0]  gf;
    logic [7:0]  bf;

    logic [7:0]  frac_max;
    logic [7:0]  frac_min;
    logic [7:0]  rg_diff;
    logic [2:0]  class_color;

`ifdef RGB_CLASSIFIER_AVG_EN
    logic [17:0] acc_r;
    logic [17:0] acc_g;
    logic [17:0] acc_b;
    logic [1:0]  avg_cnt;
    logic        avg_go;
`endif

    assign in_g = i_rgb_value[15:0];
    assign in_r = i_rgb_value[31:16];
    assign in_b = i_rgb_value[47:32];

    assign o_busy = (state != ST_IDLE);

    // Channel sum and dark test, evaluated from the latched sample in SUM.
    assign sum_comb = {2'b00, r_val} + {2'b00, g_val} + {2'b00, b_val};
    assign sum_dark = (sum_comb < DARK_MIN_W);

    // One restoring-division step.
    // The partial remainder never exceeds S, so doubling it fits in 19 bits.
    // When X equals S, every step subtracts, so the fraction saturates to 255
    // without a separate clamp.
    always_comb begin
        div_trial    = {div_rem, 1'b0};
        div_qbit     = (div_trial >= {1'b0, sum_val});
        div_rem_next = div_qbit ? 18'(div_trial - {1'b0, sum_val}) : div_trial[17:0];
        div_frac     = {div_quot, div_qbit};
        div_last     = (div_bit == 3'd7) && (div_chan == 2'd2);
    end

    // Colour rules, checked in priority order from the registered fractions.
    // The dark override is applied when the result is registered in CLASS.
    always_comb begin
        frac_max    = rf;
        frac_min    = rf;
        rg_diff     = 8'd0;
        class_color = COLOR_RED;

        if (gf > frac_max) frac_max = gf;
        if (bf > frac_max) frac_max = bf;
        if (gf < frac_min) frac_min = gf;
        if (bf < frac_min) frac_min = bf;
        rg_diff = (rf >= gf) ? (rf - gf) : (gf - rf);

        if ((frac_max - frac_min) <= WHITE_SPREAD_W)
            class_color = COLOR_WHITE;
        else if ((bf >= rf) && (bf >= gf))
            class_color = COLOR_BLUE;
        else if ((rg_diff <= YELLOW_TOL_W) && (bf <= YELLOW_B_MAX_W))
            class_color = COLOR_YELLOW;
        else if (gf > rf)
            class_color = COLOR_GREEN;
        else if (gf >= ORANGE_G_MIN_W)
            class_color = COLOR_ORANGE;
        else
            class_color = COLOR_RED;
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic.
    // In averaging builds, SUM falls straight back to IDLE until the fourth
    // sample has been accumulated.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (i_start)
                    state_next = ST_SUM;
            end
            ST_SUM: begin
                if (sum_dark)
                    state_next = ST_CLASS;
                else
                    state_next = ST_DIV;
`ifdef RGB_CLASSIFIER_AVG_EN
                if (!avg_go)
                    state_next = ST_IDLE;
`endif
            end
            ST_DIV: begin
                if (div_last)
                    state_next = ST_CLASS;
            end
            ST_CLASS: begin
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (i_ack)
                    state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: latches the sample, runs the divider and registers the result.
    // The divider works through R, then G, then B. Each channel takes eight
    // cycles. On the last cycle of a channel, the next channel's dividend is
    // loaded.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_val    <= '0;
            g_val    <= '0;
            b_val    <= '0;
            sum_val  <= '0;
            dark     <= 1'b0;
            div_rem  <= '0;
            div_quot <= '0;
            div_bit  <= '0;
            div_chan <= '0;
            rf       <= '0;
            gf       <= '0;
            bf       <= '0;
            o_color  <= COLOR_UNKNOWN;
            o_valid  <= 1'b0;
`ifdef RGB_CLASSIFIER_AVG_EN
            acc_r    <= '0;
            acc_g    <= '0;
            acc_b    <= '0;
            avg_cnt  <= '0;
            avg_go   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
`ifdef RGB_CLASSIFIER_AVG_EN
                        acc_r   <= acc_r + {2'b00, in_r};
                        acc_g   <= acc_g + {2'b00, in_g};
                        acc_b   <= acc_b + {2'b00, in_b};
                        r_val   <= 16'((acc_r + {2'b00, in_r}) >> 2);
                        g_val   <= 16'((acc_g + {2'b00, in_g}) >> 2);
                        b_val   <= 16'((acc_b + {2'b00, in_b}) >> 2);
                        avg_cnt <= avg_cnt + 2'd1;
                        avg_go  <= (avg_cnt == 2'd3);
`else
                        r_val <= in_r;
                        g_val <= in_g;
                        b_val <= in_b;
`endif
                    end
                end
                ST_SUM: begin
                    sum_val  <= sum_comb;
                    dark     <= sum_dark;
                    div_rem  <= {2'b00, r_val};
                    div_quot <= '0;
                    div_bit  <= '0;
                    div_chan <= '0;
                end
                ST_DIV: begin
                    div_bit <= div_bit + 3'd1;
                    if (div_bit == 3'd7) begin
                        div_quot <= '0;
                        div_chan <= div_chan + 2'd1;
                        case (div_chan)
                            2'd0: begin
                                rf      <= div_frac;
                                div_rem <= {2'b00, g_val};
                            end
                            2'd1: begin
                                gf      <= div_frac;
                                div_rem <= {2'b00, b_val};
                            end
                            default: begin
                                bf <= div_frac;
                            end
                        endcase
                    end else begin
                        div_quot <= div_frac[6:0];
                        div_rem  <= div_rem_next;
                    end
                end
                ST_CLASS: begin
                    o_color <= dark ? COLOR_UNKNOWN : class_color;
                    o_valid <= 1'b1;
`ifdef RGB_CLASSIFIER_AVG_EN
                    acc_r   <= '0;
                    acc_g   <= '0;
                    acc_b   <= '0;
                    avg_cnt <= '0;
`endif
                end
                ST_HOLD: begin
                    if (i_ack)
                        o_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_classifier.sv
// ---------------------------------------------------------------------------
// tb_rgb_classifier
//
// Purpose:
//   Self-checking bench for rgb_classifier.
//   - A table of directed samples is checked for colour and latency.
//   - Hand-written sequences cover the handshake, ignored strobes and
//     reset in the middle of a division.
//   - When RGB_CLASSIFIER_AVG_EN is defined, each sample is sent four
//     times, and a sequence with varying R values is added.
// ---------------------------------------------------------------------------
module tb_rgb_classifier;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [47:0] i_rgb_value;
    logic        i_ack;
    logic [2:0]  o_color;
    logic        o_valid;
    logic        o_busy;

    int checks = 0;
    int errors = 0;
    int latency;

    typedef struct {
        string       name;
        logic [15:0] r;
        logic [15:0] g;
        logic [15:0] b;
        int          color;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    always #5 i_clk = ~i_clk;

    rgb_classifier dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_rgb_value (i_rgb_value),
        .i_ack       (i_ack),
        .o_color     (o_color),
        .o_valid     (o_valid),
        .o_busy      (o_busy)
    );

    // Hard stop in case something wedges the stimulus itself.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [47:0] packRgb(input logic [15:0] r, input logic [15:0] g,
                                            input logic [15:0] b);
        return {b, r, g};
    endfunction

    task automatic setVec(input int idx, input string name, input logic [15:0] r,
                          input logic [15:0] g, input logic [15:0] b,
                          input int color, input int lat);
        vecs[idx].name  = name;
        vecs[idx].r     = r;
        vecs[idx].g     = g;
        vecs[idx].b     = b;
        vecs[idx].color = color;
        vecs[idx].lat   = lat;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drives one start strobe.
    // Returns at the falling edge after the sampling edge, with latency reset.
    task automatic pulseStart(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
        @(negedge i_clk);
        i_rgb_value = packRgb(r, g, b);
        i_start     = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        latency = 0;
    endtask

    // Sends a sample. Averaging builds need three leading starts first, and
    // each of those must return to IDLE with no o_valid.
    task automatic applyStimulus(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
`ifdef RGB_CLASSIFIER_AVG_EN
        repeat (3) begin
            pulseStart(r, g, b);
            @(posedge i_clk);
            @(negedge i_clk);
            checkOutput("avg_pre_valid", int'(o_valid), 0);
            checkOutput("avg_pre_busy", int'(o_busy), 0);
        end
`endif
        pulseStart(r, g, b);
    endtask

    // Counts edges since the start edge until o_valid is seen.
    task automatic waitValid();
        while (!o_valid && latency < 60) begin
            @(posedge i_clk);
            latency++;
            @(negedge i_clk);
        end
    endtask

    // Acknowledges the held result and checks the return to IDLE.
    task automatic handshake(input string name, input int expColor);
        @(negedge i_clk);
        i_ack = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_ack = 1'b0;
        checkOutput({name, "_ack_valid"}, int'(o_valid), 0);
        checkOutput({name, "_ack_busy"}, int'(o_busy), 0);
        checkOutput({name, "_ack_color_kept"}, int'(o_color), expColor);
    endtask

    initial begin
        bit stable;
        bit quiet;

        setVec(0, "white",  16'd1000, 16'd1000, 16'd1000, 0, 26);
        setVec(1, "yellow", 16'd2000, 16'd1800, 16'd200,  1, 26);
        setVec(2, "orange", 16'd2400, 16'd1200, 16'd400,  2, 26);
        setVec(3, "red",    16'd3000, 16'd600,  16'd400,  3, 26);
        setVec(4, "blue",   16'd200,  16'd500,  16'd1300, 5, 26);
        setVec(5, "green",  16'd300,  16'd1500, 16'd700,  4, 26);
        setVec(6, "satred", 16'd5000, 16'd0,    16'd0,    3, 26);
        setVec(7, "dark",   16'd10,   16'd10,   16'd10,   7, 2);
        setVec(8, "zero",   16'd0,    16'd0,    16'd0,    7, 2);

        i_rst       = 1'b1;
        i_start     = 1'b0;
        i_ack       = 1'b0;
        i_rgb_value = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checkOutput("reset_valid", int'(o_valid), 0);
        checkOutput("reset_busy", int'(o_busy), 0);
        checkOutput("reset_color", int'(o_color), 7);
        i_rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].r, vecs[i].g, vecs[i].b);
            waitValid();
            checkOutput({vecs[i].name, "_latency"}, latency, vecs[i].lat);
            checkOutput({vecs[i].name, "_color"}, int'(o_color), vecs[i].color);
            checkOutput({vecs[i].name, "_busy_hold"}, int'(o_busy), 1);
            handshake(vecs[i].name, vecs[i].color);
        end

        // Extra start and stray ack during DIV, long hold, then ack+start in HOLD.
        applyStimulus(16'd1000, 16'd1000, 16'd1000);
        repeat (5) begin
            @(posedge i_clk);
            latency++;
            @(negedge i_clk);
        end
        i_rgb_value = packRgb(16'd5000, 16'd0, 16'd0);
        i_start     = 1'b1;
        i_ack       = 1'b1;
        @(posedge i_clk);
        latency++;
        @(negedge i_clk);
        i_start = 1'b0;
        i_ack   = 1'b0;
        waitValid();
        checkOutput("midstart_latency", latency, 26);
        checkOutput("midstart_color", int'(o_color), 0);

        stable = 1'b1;
        repeat (100) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (!o_valid || o_color != 3'd0)
                stable = 1'b0;
        end
        checkOutput("hold_stable", int'(stable), 1);

        i_rgb_value = packRgb(16'd5000, 16'd0, 16'd0);
        i_start     = 1'b1;
        i_ack       = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        i_ack   = 1'b0;
        checkOutput("ackstart_valid", int'(o_valid), 0);
        checkOutput("ackstart_busy", int'(o_busy), 0);
        checkOutput("ackstart_color", int'(o_color), 0);
        quiet = 1'b1;
        repeat (30) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_valid || o_busy)
                quiet = 1'b0;
        end
        checkOutput("no_queued_start", int'(quiet), 1);

        // Reset on DIV cycle 10: the start edge is k, DIV begins at k+2,
        // and the reset is sampled at edge k+11.
        applyStimulus(16'd2000, 16'd1800, 16'd200);
        repeat (10) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        checkOutput("midreset_valid", int'(o_valid), 0);
        checkOutput("midreset_color", int'(o_color), 7);
        checkOutput("midreset_busy", int'(o_busy), 0);
        quiet = 1'b1;
        repeat (40) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_valid)
                quiet = 1'b0;
        end
        checkOutput("midreset_no_pulse", int'(quiet), 1);

        applyStimulus(16'd200, 16'd500, 16'd1300);
        waitValid();
        checkOutput("after_reset_latency", latency, 26);
        checkOutput("after_reset_color", int'(o_color), 5);
        handshake("after_reset", 5);

`ifdef RGB_CLASSIFIER_AVG_EN
        // R values average to 1000, so the four-sample mean is white.
        pulseStart(16'd1000, 16'd1000, 16'd1000);
        @(posedge i_clk);
        @(negedge i_clk);
        checkOutput("avgseq_valid1", int'(o_valid), 0);
        pulseStart(16'd1200, 16'd1000, 16'd1000);
        @(posedge i_clk);
        @(negedge i_clk);
        checkOutput("avgseq_valid2", int'(o_valid), 0);
        pulseStart(16'd800, 16'd1000, 16'd1000);
        @(posedge i_clk);
        @(negedge i_clk);
        checkOutput("avgseq_valid3", int'(o_valid), 0);
        pulseStart(16'd1000, 16'd1000, 16'd1000);
        waitValid();
        checkOutput("avgseq_latency", latency, 26);
        checkOutput("avgseq_color", int'(o_color), 0);
        handshake("avgseq", 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
